inst_prefetch: RTL

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/inst_prefetch_if.sv | 33 +++
 rtl/inst_prefetch.sv | 136 +++++++++++++
 2 files changed

// File: rtl/inst_prefetch_if.sv
// Signal bundle between the instruction prefetcher, its serial memory port and the decoder.
// The prefetcher takes the master modport; the memory/decoder side takes slave.
interface inst_prefetch_if #(
  parameter int NSHIFT = 2
);
  logic              fetch_req;
  logic [15:0]       fetch_addr;
  logic              fetch_started;
  logic              rx_data_valid;
  logic [NSHIFT-1:0] rx_data;
  logic              rx_done;
  logic              inst_valid;
  logic [15:0]       inst;
  logic              inst_done;
  logic              load_imm16;
  logic              imm16_loaded;
  logic              next_imm_data;
  logic [NSHIFT-1:0] imm_data_in;
  logic              flush;
  logic [15:0]       flush_pc;

  modport master (
    output fetch_req, fetch_addr, inst_valid, inst, imm16_loaded, imm_data_in,
    input  fetch_started, rx_data_valid, rx_data, rx_done, inst_done, load_imm16,
           next_imm_data, flush, flush_pc
  );

  modport slave (
    input  fetch_req, fetch_addr, inst_valid, inst, imm16_loaded, imm_data_in,
    output fetch_started, rx_data_valid, rx_data, rx_done, inst_done, load_imm16,
           next_imm_data, flush, flush_pc
  );
endinterface

// File: rtl/inst_prefetch.sv
// Two-entry instruction prefetch queue fed by a serial (NSHIFT bits/cycle) memory port.
// Define INST_PREFETCH_AHEAD_EN to fetch whenever the queue has room, not only on demand.
module inst_prefetch #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 16 / NSHIFT
) (
  input  logic            clk,
  input  logic            reset,
  inst_prefetch_if.master bus
);
  localparam int ASM_W = NSHIFT * PAYLOAD_CYCLES;

  typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

  state_t           state_q, state_d;
  logic [15:0]      ptr_q, ptr_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      entry0_q, entry0_d;
  logic [15:0]      entry1_q, entry1_d;
  logic             imm_used_q, imm_used_d;
  logic             discard_q, discard_d;
  logic [ASM_W-1:0] asm_q, asm_d;

  logic             in_flight, room, fetch_ok;
  logic             word_done, word_write, loaded, imm_shift, pop_req;
  logic [ASM_W-1:0] asm_shifted;
  logic [15:0]      word_new;

  assign in_flight   = (state_q != IDLE);
  assign room        = ((3'(count_q) + 3'(in_flight)) < 3'd2) && !discard_q;
`ifdef INST_PREFETCH_AHEAD_EN
  assign fetch_ok    = room;
`else
  assign fetch_ok    = room && ((count_q == 2'd0) || ((count_q == 2'd1) && bus.load_imm16));
`endif

  // Last payload beat coincides with rx_done, so the completed word is the shifted value.
  assign asm_shifted = {bus.rx_data, asm_q[ASM_W-1:NSHIFT]};
  assign word_new    = asm_shifted[ASM_W-1 -: 16];
  assign word_done   = (state_q == RECV) && bus.rx_done;
  assign word_write  = word_done && !discard_q && !bus.flush;
  assign loaded      = bus.load_imm16 && (count_q == 2'd2);
  assign imm_shift   = bus.next_imm_data && loaded;
  assign pop_req     = bus.inst_done && (count_q != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_ok && !bus.flush) state_d = REQ;
      // An accepted request still returns data, so it is received and discarded.
      REQ:     if (bus.fetch_started) state_d = RECV;
               else if (bus.flush)    state_d = IDLE;
      RECV:    if (bus.rx_done)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_req = (state_q == REQ);
  end

  always_comb begin
    ptr_d      = ptr_q;
    count_d    = count_q;
    entry0_d   = entry0_q;
    entry1_d   = entry1_q;
    imm_used_d = imm_used_q;
    discard_d  = discard_q;
    asm_d      = asm_q;

    if ((state_q == RECV) && bus.rx_data_valid) asm_d = asm_shifted;

    if (word_done)
      discard_d = 1'b0;
    else if (bus.flush && ((state_q == RECV) || ((state_q == REQ) && bus.fetch_started)))
      discard_d = 1'b1;

    if (bus.flush) begin
      count_d    = 2'd0;
      imm_used_d = 1'b0;
      ptr_d      = bus.flush_pc;
    end else begin
      if (imm_shift) begin
        entry1_d   = entry1_q >> NSHIFT;
        imm_used_d = 1'b1;
      end
      if (pop_req) begin
        imm_used_d = 1'b0;
        if (imm_used_q) begin
          count_d = 2'd0;
        end else begin
          count_d  = count_q - 2'd1;
          entry0_d = entry1_d;
        end
      end
      // Write lands at the post-pop position; the fetch gate keeps this below two entries.
      if (word_write) begin
        ptr_d = ptr_q + 16'd2;
        if (count_d == 2'd0) entry0_d = word_new;
        else                 entry1_d = word_new;
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= 16'h0000;
      count_q    <= 2'd0;
      entry0_q   <= 16'h0000;
      entry1_q   <= 16'h0000;
      imm_used_q <= 1'b0;
      discard_q  <= 1'b0;
      asm_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      imm_used_q <= imm_used_d;
      discard_q  <= discard_d;
      asm_q      <= asm_d;
    end
  end

  assign bus.fetch_addr   = ptr_q;
  assign bus.inst_valid   = (count_q != 2'd0);
  assign bus.inst         = entry0_q;
  assign bus.imm16_loaded = loaded;
  assign bus.imm_data_in  = entry1_q[NSHIFT-1:0];
endmodule
